bus_arbiter3x1: RTL
===================

Name: bus_arbiter3x1

Overview:
- Round-robin arbiter sharing one pipelined bus target (SRAM or peripheral port) between three masters.
- Sits between the masters and a single target port.
- Forwards one granted request per cycle, propagates target back-pressure (hold) and steers returned read data to the issuing master.
- Uses an in-flight tag pipeline sized to the target's read latency.

Parameters:
- RD_LATENCY, 1: cycles from an accepted read to valid t_rdata; legal range 1..4.
- AW, 32: address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- m_addr  in  3*AW  master addresses; master i at bits [i*AW +: AW].
- m_read  in  3  per-master read strobe.
- m_write  in  3  per-master write strobe.
- m_wdata  in  96  per-master write data, 32 bits each.
- m_wbe  in  12  per-master byte enables, 4 bits each.
- m_hold  out  3  per-master hold; request not accepted this cycle.
- m_rdata  out  96  per-master read data.
- t_addr  out  AW  target address.
- t_read  out  1  target read strobe.
- t_write  out  1  target write strobe.
- t_wdata  out  32  target write data.
- t_wbe  out  4  target byte enables.
- t_hold  in  1  target hold.
- t_rdata  in  32  target read data.

Behaviour:
- Master i requests when m_read[i] | m_write[i].
- A master must keep its request stable while its m_hold[i]=1.
- Reset (rst=0, async):
  - prio pointer = 0, so master 0 has highest priority.
  - lock = 0, in-flight tag pipeline cleared.
  - With all requests low: t_read = t_write = 0, m_hold = 0, m_rdata = 0.
- Grant selection:
  - lock=0: grant goes to the first requesting master scanning prio, prio+1, prio+2 (mod 3).
  - lock=1: grant stays with locked_id.
  - Purely combinational from the current requests; no added latency.
- Target drive:
  - Granted master's addr/read/write/wdata/wbe are routed to t_*.
  - No request: t_read = t_write = 0, and t_addr/t_wdata/t_wbe are driven 0.
- Hold:
  - m_hold[g] = t_hold for the granted master g.
  - Every other requesting master gets m_hold = 1.
  - Non-requesting masters get m_hold = 0.
- Lock:
  - Grant issued with t_hold=1: next cycle lock=1, locked_id=g.
  - First cycle with t_hold=0 (acceptance): lock clears.
  - The grant must never change while the target holds.
- Rotation: on acceptance, prio <= (g+1) mod 3. Otherwise prio is unchanged.
- Read return:
  - Accepted read pushes tag {valid=1, id=g} into an RD_LATENCY-deep shift pipeline; every other cycle pushes valid=0.
  - The pipeline shifts every cycle, independent of t_hold.
  - At pipeline output, if valid: m_rdata[id] = t_rdata and all other m_rdata = 0.
  - If not valid: all m_rdata = 0.
- Combined access: read and write from the same master in one cycle are forwarded together and count as one grant. Only the read pushes a valid tag.
- Master dropping its request while locked (protocol violation):
  - lock clears the same cycle.
  - Arbitration proceeds as if lock=0.
- Reset asserted mid-operation: in-flight tags are discarded; their read data is never delivered.

Optional Feature:
- Macro ARB_PERF_EN.
- Defined:
  - Adds output m_stall_cnt, 3*16 bits.
  - Per-master saturating counter of cycles with request=1 and m_hold=1.
  - Counter i saturates at 16'hFFFF; cleared by reset.
- Undefined: port and counters absent; no other behavioural difference.

Test Plan:
- Single master: m1 reads 0x40000010, t_rdata=0xDEADBEEF one cycle later (RD_LATENCY=1) -> m_hold=000, m_rdata[1]=0xDEADBEEF, m_rdata[0]=m_rdata[2]=0.
- Contention: all three masters read continuously from reset, t_hold=0 -> grant order 0,1,2,0,1,2. Each master's read data lands only on its own m_rdata slice.
- Target hold: m2 writes 0x12345678/wbe=F while t_hold=1 for 3 cycles and m0 requests meanwhile -> t_addr/t_wdata stay m2's for all 4 cycles, m_hold[0]=1 throughout. After acceptance the next grant goes to m0.
- Latency: RD_LATENCY=3, back-to-back reads m0 then m1 -> rdata routed to m0 at cycle +3 and to m1 at cycle +4.
- Reset mid-read: assert rst=0 one cycle after accepting m0's read -> no m_rdata delivered after reset release, prio=0.
- ARB_PERF_EN: m0 and m1 request 10 cycles with t_hold=0 -> m_stall_cnt[1] increments on each cycle it is not granted (5), m_stall_cnt[0]=5, m_stall_cnt[2]=0.

Source files
------------

// File: rtl/bus_arbiter3x1_if.sv
// Bus bundle between three masters, the arbiter and a single target port.
// Optional macro ARB_PERF_EN adds the per-master stall counter output.
// The master modport is the environment side (masters plus target model);
// the slave modport is the arbiter side.
interface bus_arbiter3x1_if #(
    parameter int AW = 32
);
    logic [3*AW-1:0] m_addr;
    logic [2:0]      m_read;
    logic [2:0]      m_write;
    logic [95:0]     m_wdata;
    logic [11:0]     m_wbe;
    logic [2:0]      m_hold;
    logic [95:0]     m_rdata;
    logic [AW-1:0]   t_addr;
    logic            t_read;
    logic            t_write;
    logic [31:0]     t_wdata;
    logic [3:0]      t_wbe;
    logic            t_hold;
    logic [31:0]     t_rdata;
`ifdef ARB_PERF_EN
    logic [47:0]     m_stall_cnt;
`endif

    modport master (
        output m_addr, m_read, m_write, m_wdata, m_wbe, t_hold, t_rdata,
`ifdef ARB_PERF_EN
        input  m_stall_cnt,
`endif
        input  m_hold, m_rdata, t_addr, t_read, t_write, t_wdata, t_wbe
    );

    modport slave (
        input  m_addr, m_read, m_write, m_wdata, m_wbe, t_hold, t_rdata,
`ifdef ARB_PERF_EN
        output m_stall_cnt,
`endif
        output m_hold, m_rdata, t_addr, t_read, t_write, t_wdata, t_wbe
    );
endinterface

// File: rtl/bus_arbiter3x1.sv
// Round-robin arbiter sharing one pipelined target between three masters.
// Grants are combinational, held while the target stalls, and read data is
// steered back through a tag pipeline RD_LATENCY (1..4) cycles deep.
// Optional macro ARB_PERF_EN adds saturating per-master stall counters.
module bus_arbiter3x1 #(
    parameter int RD_LATENCY = 1,
    parameter int AW         = 32
) (
    input logic            clk,
    input logic            rst,
    bus_arbiter3x1_if.slave bus
);

    logic [2:0] w_req;
    logic       w_anyReq;
    logic       w_lockValid;
    logic [1:0] w_cand0;
    logic [1:0] w_cand1;
    logic [1:0] w_cand2;
    logic [1:0] w_grant;
    logic       w_accept;
    logic       w_pushValid;
    logic [2:0] w_hold;

    logic [1:0] r_prio;
    logic       r_lock;
    logic [1:0] r_lockedId;
    logic       r_tagValid [RD_LATENCY];
    logic [1:0] r_tagId    [RD_LATENCY];

    function automatic logic [1:0] nextId(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

    function automatic logic bitOf(input logic [2:0] vec, input logic [1:0] id);
        case (id)
            2'd0:    return vec[0];
            2'd1:    return vec[1];
            default: return vec[2];
        endcase
    endfunction

    assign w_req       = bus.m_read | bus.m_write;
    assign w_anyReq    = |w_req;
    // A lock only counts while the locked master still requests; a dropped
    // request falls back to normal round-robin in the same cycle.
    assign w_lockValid = r_lock & bitOf(w_req, r_lockedId);
    assign w_cand0     = r_prio;
    assign w_cand1     = nextId(r_prio);
    assign w_cand2     = nextId(w_cand1);
    assign w_accept    = w_anyReq & ~bus.t_hold;
    assign w_pushValid = w_accept & bitOf(bus.m_read, w_grant);

    // Pick the granted master: locked owner first, else scan from the pointer
    always_comb begin
        if (w_lockValid)
            w_grant = r_lockedId;
        else if (bitOf(w_req, w_cand0))
            w_grant = w_cand0;
        else if (bitOf(w_req, w_cand1))
            w_grant = w_cand1;
        else if (bitOf(w_req, w_cand2))
            w_grant = w_cand2;
        else
            w_grant = r_prio;
    end

    // Route the granted master onto the target port, zeros when idle
    always_comb begin
        bus.t_addr  = '0;
        bus.t_read  = 1'b0;
        bus.t_write = 1'b0;
        bus.t_wdata = '0;
        bus.t_wbe   = '0;
        for (int i = 0; i < 3; i++) begin
            if (w_anyReq && (w_grant == 2'(i))) begin
                bus.t_addr  = bus.m_addr[i*AW +: AW];
                bus.t_read  = bus.m_read[i];
                bus.t_write = bus.m_write[i];
                bus.t_wdata = bus.m_wdata[i*32 +: 32];
                bus.t_wbe   = bus.m_wbe[i*4 +: 4];
            end
        end
    end

    // Granted master sees the target hold, losing requesters are always held
    always_comb begin
        w_hold = '0;
        for (int i = 0; i < 3; i++)
            w_hold[i] = w_req[i] & ((w_grant == 2'(i)) ? bus.t_hold : 1'b1);
    end

    assign bus.m_hold = w_hold;

    // Lock the grant across target stalls and rotate priority on acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio     <= 2'd0;
            r_lock     <= 1'b0;
            r_lockedId <= 2'd0;
        end else begin
            if (w_anyReq && bus.t_hold) begin
                r_lock     <= 1'b1;
                r_lockedId <= w_grant;
            end else begin
                r_lock     <= 1'b0;
            end
            if (w_accept)
                r_prio <= nextId(w_grant);
        end
    end

    // Shift the read tag pipeline every cycle regardless of target hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_tagValid[k] <= 1'b0;
                r_tagId[k]    <= 2'd0;
            end
        end else begin
            r_tagValid[0] <= w_pushValid;
            r_tagId[0]    <= w_grant;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_tagValid[k] <= r_tagValid[k-1];
                r_tagId[k]    <= r_tagId[k-1];
            end
        end
    end

    // Steer returning read data only to the master named by the oldest tag
    always_comb begin
        bus.m_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (r_tagValid[RD_LATENCY-1] && (r_tagId[RD_LATENCY-1] == 2'(i)))
                bus.m_rdata[i*32 +: 32] = bus.t_rdata;
        end
    end

`ifdef ARB_PERF_EN
    logic [15:0] r_stallCnt [3];

    // Count cycles each master spends requesting while held, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++)
                r_stallCnt[i] <= 16'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_req[i] && w_hold[i] && (r_stallCnt[i] != 16'hFFFF))
                    r_stallCnt[i] <= r_stallCnt[i] + 16'd1;
            end
        end
    end

    assign bus.m_stall_cnt = {r_stallCnt[2], r_stallCnt[1], r_stallCnt[0]};
`endif

endmodule
